// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: N_CH independent counters, each
// producing a 50% square wave or a one-cycle strobe at its terminal count.

module clock_divider_multi_ch #(
    parameter int WIDTH       = 24,
    parameter int DEFAULT_DIV = 1250000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             wr_hit,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic             clk_out,
    output logic             tick
);
    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic             mode;   // 0 = square, 1 = pulse
    } cfg_t;

    cfg_t             cfg_q;
    logic [WIDTH-1:0] cnt_q;
    logic             term;

    assign term = (cnt_q == cfg_q.div);

    // Priority: reset, then write, then disable, then counting. A write that
    // lands on a terminal count therefore suppresses that toggle/tick.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cfg_q.div  <= WIDTH'(DEFAULT_DIV);
            cfg_q.mode <= 1'b0;
            cnt_q      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else if (wr_hit) begin
            cfg_q.div  <= wr_div;
            cfg_q.mode <= wr_mode;
            cnt_q      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (term) begin
            cnt_q   <= '0;
            tick    <= 1'b1;
            clk_out <= cfg_q.mode ? 1'b1 : ~clk_out;
        end else begin
            cnt_q <= cnt_q + WIDTH'(1);
            tick  <= 1'b0;
            if (cfg_q.mode)
                clk_out <= 1'b0;
        end
    end
endmodule

module clock_divider_multi #(
    parameter  int N_CH        = 4,
    parameter  int WIDTH       = 24,
    parameter  int DEFAULT_DIV = 1250000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_mode,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);
    logic [N_CH-1:0] wr_hit;

    // Exact-match decode: out-of-range channel numbers select nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++)
            wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clock_divider_multi_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[i]),
            .wr_hit  (wr_hit[i]),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end
endmodule
